// File: rtl/sr_reg_bank_pkg.sv
// sr_reg_bank_pkg
// Holds the mode and SR-priority encodings shared by the register bank and
// its per-channel cell, plus the single-bit next-state function.
package sr_reg_bank_pkg;

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam int PRIO_HOLD = 0;
  localparam int PRIO_SET  = 1;
  localparam int PRIO_RST  = 2;

  // Next value of one stored bit. r is don't-care in D and T modes.
  function automatic logic sr_next_bit(input logic [1:0] mode,
                                       input int         prio,
                                       input logic       q,
                                       input logic       s,
                                       input logic       r);
    logic nxt;
    nxt = q;
    case (mode)
      MODE_SR: begin
        case ({s, r})
          2'b10:   nxt = 1'b1;
          2'b01:   nxt = 1'b0;
          2'b11: begin
            if (prio == PRIO_SET)      nxt = 1'b1;
            else if (prio == PRIO_RST) nxt = 1'b0;
            else                       nxt = q;
          end
          default: nxt = q;
        endcase
      end
      MODE_JK: begin
        case ({s, r})
          2'b10:   nxt = 1'b1;
          2'b01:   nxt = 1'b0;
          2'b11:   nxt = ~q;
          default: nxt = q;
        endcase
      end
      MODE_D:  nxt = s;
      default: nxt = s ? ~q : q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_reg_bank_cell.sv
// sr_cell
// One storage channel: q, qn and the registered conflict flag.
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   en_i, mode_i        update enable and mode (SR/JK/D/T)
//   s_i, r_i            S/J/D/T and R/K inputs
//   q_o, qn_o           stored state and its registered complement
//   conflict_o          registered S=R=1 flag (SR mode, en high)
//   conflict_d_o        next value of conflict, used by the top-level counter
module sr_cell
  import sr_reg_bank_pkg::*;
#(
  parameter int   SR_PRIO  = PRIO_HOLD,
  parameter logic INIT_BIT = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  input  logic       s_i,
  input  logic       r_i,
  output logic       q_o,
  output logic       qn_o,
  output logic       conflict_o,
  output logic       conflict_d_o
);

  logic q_q, q_d;
  logic qn_q;
  logic conflict_q, conflict_d;

  always_comb begin
    q_d        = q_q;
    conflict_d = 1'b0;
    if (en_i) begin
      q_d        = sr_next_bit(mode_i, SR_PRIO, q_q, s_i, r_i);
      conflict_d = (mode_i == MODE_SR) && s_i && r_i;
    end
  end

  // qn is its own flop so it is a clean register output, not an inverter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q        <= INIT_BIT;
      qn_q       <= ~INIT_BIT;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      qn_q       <= ~q_d;
      conflict_q <= conflict_d;
    end
  end

  assign q_o          = q_q;
  assign qn_o         = qn_q;
  assign conflict_o   = conflict_q;
  assign conflict_d_o = conflict_d;

endmodule

// File: rtl/sr_reg_bank.sv
// sr_reg_bank
// Bank of N independent set/clear flag channels with run-time SR/JK/D/T mode,
// per-channel S=R conflict flags and a saturating conflict-cycle counter.
// Optional macro SR_REG_BANK_SYNC_IN_EN adds 2-flop synchronisers on s and r.
// Ports:
//   clk, rst (sync, active low), en, mode[1:0], s[N], r[N], cnt_clr
//   q[N], qn[N], conflict[N], conflict_cnt[CNT_W]
module sr_reg_bank
  import sr_reg_bank_pkg::*;
#(
  parameter int           N       = 8,
  parameter logic [N-1:0] INIT    = '0,
  parameter int           SR_PRIO = PRIO_HOLD,
  parameter int           CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     s,
  input  logic [N-1:0]     r,
  input  logic             cnt_clr,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qn,
  output logic [N-1:0]     conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]     s_use, r_use;
  logic [N-1:0]     conflict_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef SR_REG_BANK_SYNC_IN_EN
  logic [N-1:0] s_meta_q, s_sync_q, r_meta_q, r_sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_meta_q <= '0;
      s_sync_q <= '0;
      r_meta_q <= '0;
      r_sync_q <= '0;
    end else begin
      s_meta_q <= s;
      s_sync_q <= s_meta_q;
      r_meta_q <= r;
      r_sync_q <= r_meta_q;
    end
  end

  assign s_use = s_sync_q;
  assign r_use = r_sync_q;
`else
  assign s_use = s;
  assign r_use = r;
`endif

  for (genvar i = 0; i < N; i++) begin : g_cell
    sr_cell #(
      .SR_PRIO  (SR_PRIO),
      .INIT_BIT (INIT[i])
    ) u_cell (
      .clk_i        (clk),
      .rst_ni       (rst),
      .en_i         (en),
      .mode_i       (mode),
      .s_i          (s_use[i]),
      .r_i          (r_use[i]),
      .q_o          (q[i]),
      .qn_o         (qn[i]),
      .conflict_o   (conflict[i]),
      .conflict_d_o (conflict_d[i])
    );
  end

  // Counts cycles, not channels: one step per edge with any conflict pending.
  // conflict_d is already 0 when en is low, so the count holds then.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if ((|conflict_d) && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_reg_bank.sv
module tb_sr_reg_bank;
  import sr_reg_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, cnt_clr;
  logic [1:0] mode;
  logic [7:0] s, r;

  logic [7:0] q0, qn0, cf0, cnt0;
  logic [7:0] q1, qn1, cf1;
  logic [1:0] cnt1;
  logic [7:0] q2, qn2, cf2, cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sr_reg_bank #(.N(8), .INIT(8'hA5), .SR_PRIO(PRIO_HOLD), .CNT_W(8)) u_p0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .cnt_clr(cnt_clr),
    .q(q0), .qn(qn0), .conflict(cf0), .conflict_cnt(cnt0));

  sr_reg_bank #(.N(8), .INIT(8'hA5), .SR_PRIO(PRIO_SET), .CNT_W(2)) u_p1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .cnt_clr(cnt_clr),
    .q(q1), .qn(qn1), .conflict(cf1), .conflict_cnt(cnt1));

  sr_reg_bank #(.N(8), .INIT(8'hA5), .SR_PRIO(PRIO_RST), .CNT_W(8)) u_p2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .cnt_clr(cnt_clr),
    .q(q2), .qn(qn2), .conflict(cf2), .conflict_cnt(cnt2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] sv, input logic [7:0] rv);
    mode = m;
    s    = sv;
    r    = rv;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; cnt_clr = 1'b0;
    drive(MODE_SR, 8'h00, 8'h00);

    // reset
    tick(); tick();
    chk("rst_q",   {24'h0, q0},   32'hA5);
    chk("rst_qn",  {24'h0, qn0},  32'h5A);
    chk("rst_cf",  {24'h0, cf0},  32'h00);
    chk("rst_cnt", {24'h0, cnt0}, 32'h00);

`ifdef SR_REG_BANK_SYNC_IN_EN
    rst = 1'b1; en = 1'b1;
    drive(MODE_D, 8'h00, 8'h00);
    tick(); tick(); tick();
    chk("sync_zero", {24'h0, q0}, 32'h00);
    drive(MODE_D, 8'h81, 8'h00);
    tick(); tick();
    chk("sync_t2", {24'h0, q0}, 32'h00);
    tick();
    chk("sync_t3",  {24'h0, q0},  32'h81);
    chk("sync_qn",  {24'h0, qn0}, 32'h7E);
`else
    // en low holds despite active inputs
    rst = 1'b1; en = 1'b0;
    drive(MODE_SR, 8'hFF, 8'h00);
    tick(); tick(); tick();
    chk("hold_q",  {24'h0, q0},  32'hA5);
    chk("hold_cf", {24'h0, cf0}, 32'h00);

    // SR mode
    en = 1'b1;
    drive(MODE_D, 8'h00, 8'h00);
    tick();
    chk("d_clear", {24'h0, q0}, 32'h00);
    drive(MODE_SR, 8'h0F, 8'h00);
    tick();
    chk("sr_set", {24'h0, q0}, 32'h0F);
    drive(MODE_SR, 8'hF0, 8'h0F);
    tick();
    chk("sr_setclr", {24'h0, q0}, 32'hF0);
    chk("sr_qn",     {24'h0, qn0}, 32'h0F);
    drive(MODE_SR, 8'hFF, 8'hFF);
    tick();
    chk("sr_hold",  {24'h0, q0},   32'hF0);
    chk("sr_pset",  {24'h0, q1},   32'hFF);
    chk("sr_prst",  {24'h0, q2},   32'h00);
    chk("sr_cf",    {24'h0, cf0},  32'hFF);
    chk("sr_cf2",   {24'h0, cf2},  32'hFF);
    chk("sr_cnt",   {24'h0, cnt0}, 32'h01);
    chk("sr_cnt1",  {30'h0, cnt1}, 32'h01);
    drive(MODE_SR, 8'h00, 8'h00);
    tick();
    chk("sr_cf_off", {24'h0, cf0},  32'h00);
    chk("sr_cnt_hd", {24'h0, cnt0}, 32'h01);

    // JK toggling, never a conflict
    drive(MODE_D, 8'h00, 8'h00);
    tick();
    drive(MODE_JK, 8'hFF, 8'hFF);
    tick();
    chk("jk_1", {24'h0, q0}, 32'hFF);
    chk("jk_cf", {24'h0, cf0}, 32'h00);
    tick();
    chk("jk_2", {24'h0, q0}, 32'h00);
    tick();
    chk("jk_3", {24'h0, q0}, 32'hFF);
    chk("jk_cnt", {24'h0, cnt0}, 32'h01);
    drive(MODE_JK, 8'h0F, 8'hF0);
    tick();
    chk("jk_sc", {24'h0, q0}, 32'h0F);

    // T and D
    drive(MODE_T, 8'h01, 8'hFF);
    tick();
    chk("t_1", {24'h0, q0}, 32'h0E);
    tick();
    chk("t_2", {24'h0, q0}, 32'h0F);
    drive(MODE_D, 8'h3C, 8'hFF);
    tick();
    chk("d_1", {24'h0, q0}, 32'h3C);
    chk("d_cf", {24'h0, cf0}, 32'h00);

    // en low: hold, conflict 0, cnt_clr still honoured
    en = 1'b0; cnt_clr = 1'b1;
    drive(MODE_SR, 8'hFF, 8'hFF);
    tick();
    chk("en0_q",   {24'h0, q0},   32'h3C);
    chk("en0_cf",  {24'h0, cf0},  32'h00);
    chk("en0_clr", {24'h0, cnt0}, 32'h00);

    // counter saturation with CNT_W=2
    en = 1'b1; cnt_clr = 1'b0;
    drive(MODE_SR, 8'h01, 8'h01);
    tick(); chk("sat_1", {30'h0, cnt1}, 32'h1);
    tick(); chk("sat_2", {30'h0, cnt1}, 32'h2);
    tick(); chk("sat_3", {30'h0, cnt1}, 32'h3);
    tick(); chk("sat_4", {30'h0, cnt1}, 32'h3);
    tick(); chk("sat_5", {30'h0, cnt1}, 32'h3);
    chk("cnt8_5", {24'h0, cnt0}, 32'h05);
    cnt_clr = 1'b1;
    tick();
    chk("clr_win",  {30'h0, cnt1}, 32'h0);
    chk("clr_cf",   {24'h0, cf1},  32'h01);
    chk("clr_win0", {24'h0, cnt0}, 32'h00);

    // reset mid-operation
    cnt_clr = 1'b0;
    tick();
    chk("pre_rst_cnt", {24'h0, cnt0}, 32'h01);
    drive(MODE_D, 8'h00, 8'h00);
    tick();
    drive(MODE_JK, 8'hFF, 8'hFF);
    tick();
    chk("mid_jk", {24'h0, q0}, 32'hFF);
    rst = 1'b0;
    tick();
    chk("mid_rst_q",   {24'h0, q0},   32'hA5);
    chk("mid_rst_qn",  {24'h0, qn0},  32'h5A);
    chk("mid_rst_cnt", {24'h0, cnt0}, 32'h00);
    rst = 1'b1;
    tick();
    chk("resume_1", {24'h0, q0}, 32'h5A);
    tick();
    chk("resume_2", {24'h0, q0}, 32'hA5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
